dmem_responder: RTL and testbench

- Data-memory responder for the CPU's load/store port.
- Replaces the zero-latency combinational DM with a req/ack slave that has a programmable wait-state count, 4-bit byte enables and registered read data.
- Lets the core and a future multi-cycle controller run against realistic memory timing.
- Sits between the CPU datapath (address = ALU result bits [11:2], write data = RF read port 2) and a 1K-word storage array.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_ADDR_W   = 10;
    localparam int DMEM_DATA_W   = 32;
    localparam int DMEM_BE_W     = 4;
    localparam int DMEM_WAIT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write with per-lane byte enables and a
// registered read port. No reset, so contents survive a responder reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DMEM_BE_W-1:0] be_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Lane-masked write and registered read; read data holds between reads.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < DMEM_BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// req/ack data-memory slave with WAIT_CYCLES wait states before a one-cycle ack.
// Optional build macro DMEM_STATS_EN adds saturating load/store counters
// (rd_cnt, wr_cnt).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for req; latches the request when req=1
// ST_WAIT | counting down wait states from WAIT_CYCLES to 1
// ST_RESP | ack=1 for one cycle; store/load already committed on entry
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DMEM_BE_W-1:0] be,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ack,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy
`ifdef DMEM_STATS_EN
   ,output logic [15:0]          rd_cnt,
    output logic [15:0]          wr_cnt
`endif
);

    dmem_state_e          state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DMEM_BE_W-1:0] be_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 rd_valid_q;

    logic                 latch_en;
    logic                 enter_resp;
    logic                 src_we;
    logic [ADDR_W-1:0]    src_addr;
    logic [DMEM_BE_W-1:0] src_be;
    logic [DATA_W-1:0]    src_wdata;
    logic                 arr_wr_en;
    logic                 arr_rd_en;
    logic [DATA_W-1:0]    arr_rdata;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states RESP is entered on the latching edge itself, so the
    // commit must take the live inputs; otherwise only the latched copy is used.
    assign src_we    = (state_q == ST_IDLE) ? we    : we_q;
    assign src_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    assign src_be    = (state_q == ST_IDLE) ? be    : be_q;
    assign src_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign arr_wr_en  = enter_resp &&  src_we && !rst;
    assign arr_rd_en  = enter_resp && !src_we && !rst;

    // State, counter and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                we_q    <= we;
                addr_q  <= addr;
                be_q    <= be;
                wdata_q <= wdata;
            end
            if (arr_rd_en) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .wr_en_i (arr_wr_en),
        .rd_en_i (arr_rd_en),
        .addr_i  (src_addr),
        .be_i    (src_be),
        .wdata_i (src_wdata),
        .rdata_o (arr_rdata)
    );

    // The array read register has no reset; the valid flag forces zero until
    // the first load after reset completes.
    assign rdata = rd_valid_q ? arr_rdata : '0;
    assign ack   = (state_q == ST_RESP);
    assign busy  = (state_q != ST_IDLE);

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating completion counters, bumped on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            if (arr_rd_en && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (arr_wr_en && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 2 and 15 wait
// states; the 2-wait-state instance (index 1) carries the functional tests.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [9:0]  addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        busy  [3];
`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt [3];
    logic [15:0] wr_cnt [3];
`endif

    int checks;
    int errors;
    int wc [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .be(be[0]), .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0])
`ifdef DMEM_STATS_EN
       ,.rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0])
`endif
    );

    dmem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .be(be[1]), .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1])
`ifdef DMEM_STATS_EN
       ,.rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1])
`endif
    );

    dmem_responder #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .be(be[2]), .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2])
`ifdef DMEM_STATS_EN
       ,.rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2])
`endif
    );

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Full handshake on instance i; returns rdata sampled in the ack cycle.
    task automatic do_txn(input int i, input logic w, input logic [9:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack[i] === 1'b1) begin
                got = 1'b1;
                rd  = rdata[i];
                break;
            end
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout inst=%0d addr=%0d: no ack within 40 cycles", i, a);
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d: ack=%b busy=%b rdata=%h, expected 0 0 00000000",
                         i, ack[i], busy[i], rdata[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        bit          seen_ack;
        do_txn(1, 1'b1, 10'd5, 4'hF, 32'h0000_0000, rd);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'd5; be[1] = 4'hF; wdata[1] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_busy_before: busy=%b, expected 1", busy[1]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_busy_after: busy=%b, expected 0", busy[1]);
        end
        for (int n = 0; n < 5; n++) begin
            if (ack[1] !== 1'b0) seen_ack = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen_ack) begin
            errors++;
            $display("FAIL rst_wait_no_ack: ack pulsed after reset, expected none");
        end
        @(posedge clk); #1;
        do_txn(1, 1'b0, 10'd5, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL rst_wait_store_dropped: rdata=%h, expected 00000000", rd);
        end
    endtask

    task automatic test_latency();
        logic exp_ack;
        logic exp_busy;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = 10'd0; be[i] = 4'h0; wdata[i] = 32'h0;
            for (int k = 0; k <= wc[i] + 2; k++) begin
                @(negedge clk);
                exp_ack  = (k == wc[i] + 1);
                exp_busy = (k >= 1) && (k <= wc[i] + 1);
                checks++;
                if (ack[i] !== exp_ack || busy[i] !== exp_busy) begin
                    errors++;
                    $display("FAIL latency W=%0d cycle T+%0d: ack=%b busy=%b, expected ack=%b busy=%b",
                             wc[i], k, ack[i], busy[i], exp_ack, exp_busy);
                end
                if (k == wc[i] + 1) begin
                    @(posedge clk); #1;
                    req[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        do_txn(1, 1'b1, 10'd9, 4'b1111, 32'h1122_3344, rd);
        do_txn(1, 1'b1, 10'd9, 4'b0101, 32'hAABB_CCDD, rd);
        do_txn(1, 1'b0, 10'd9, 4'b0000, 32'h0, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL byte_enable_merge: rdata=%h, expected 11bb33dd", rd);
        end
        do_txn(1, 1'b1, 10'd9, 4'b0000, 32'hFFFF_FFFF, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL rdata_hold_on_store: rdata=%h, expected 11bb33dd", rd);
        end
        do_txn(1, 1'b0, 10'd9, 4'b0000, 32'h0, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL be_zero_no_write: rdata=%h, expected 11bb33dd", rd);
        end
        do_txn(1, 1'b1, 10'd1023, 4'b1111, 32'h5A5A_A5A5, rd);
        do_txn(1, 1'b0, 10'd1023, 4'b0000, 32'h0, rd);
        checks++;
        if (rd !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL top_address: rdata=%h, expected 5a5aa5a5", rd);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        int gap;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'd3; be[1] = 4'hF; wdata[1] = 32'h0000_CAFE;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_first_ack: no ack within 40 cycles");
        end
        @(posedge clk); #1;
        we[1] = 1'b0; addr[1] = 10'd3; be[1] = 4'h0; wdata[1] = 32'h0;
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0 || ack[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b ack=%b, expected 0 0", busy[1], ack[1]);
        end
        gap = 0;
        got = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) begin
                got = 1'b1;
                gap = n;
                break;
            end
        end
        checks++;
        if (!got || gap != 3) begin
            errors++;
            $display("FAIL b2b_second_ack: ack after %0d cycles past idle (seen=%0d), expected 3",
                     gap, got);
        end
        checks++;
        if (rdata[1] !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL b2b_rdata: rdata=%h, expected 0000cafe", rdata[1]);
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
    endtask

    task automatic test_input_churn();
        logic [31:0] rd;
        bit          got;
        do_txn(1, 1'b1, 10'd7, 4'hF, 32'h1234_5678, rd);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd7; be[1] = 4'h0; wdata[1] = 32'h0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            addr[1]  = 10'd7 + 10'(n + 1);
            wdata[1] = 32'hF0F0_0000 + 32'(n);
            we[1]    = 1'b1;
            be[1]    = 4'hF;
            @(negedge clk);
            if (ack[1] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || rdata[1] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL churn_rdata: rdata=%h acked=%0d, expected 12345678", rdata[1], got);
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        do_txn(1, 1'b0, 10'd7, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL churn_mem_intact: rdata=%h, expected 12345678", rd);
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        logic [31:0] rd;
        pulse_reset();
        do_txn(1, 1'b0, 10'd1, 4'h0, 32'h0, rd);
        do_txn(1, 1'b1, 10'd2, 4'hF, 32'h0101_0101, rd);
        do_txn(1, 1'b0, 10'd2, 4'h0, 32'h0, rd);
        do_txn(1, 1'b1, 10'd2, 4'h0, 32'h0202_0202, rd);
        do_txn(1, 1'b0, 10'd3, 4'h0, 32'h0, rd);
        @(negedge clk);
        checks++;
        if (rd_cnt[1] !== 16'd3 || wr_cnt[1] !== 16'd2) begin
            errors++;
            $display("FAIL stats_counts: rd_cnt=%0d wr_cnt=%0d, expected 3 2", rd_cnt[1], wr_cnt[1]);
        end
        pulse_reset();
        @(negedge clk);
        checks++;
        if (rd_cnt[1] !== 16'd0 || wr_cnt[1] !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: rd_cnt=%0d wr_cnt=%0d, expected 0 0", rd_cnt[1], wr_cnt[1]);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        wc[0] = 0; wc[1] = 2; wc[2] = 15;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
        end
        @(posedge clk); #1;
        test_reset();
        test_reset_mid_wait();
        test_latency();
        test_byte_enables();
        test_back_to_back();
        test_input_churn();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_responder
